// File: rtl/p18_pkg.sv
// rtl/p18_pkg.sv - shared geometry, colour table, FSM encoding and cell locator for the blocks layer
package p18_pkg;

    localparam int NUM_COLS  = 8;
    localparam int NUM_ROWS  = 4;
    localparam int CELL_W    = 64;
    localparam int CELL_H    = 16;
    localparam int NUM_CELLS = NUM_COLS * NUM_ROWS;

    // Index [r] is the colour of row r (row 0 at the top).
    localparam logic [3:0][5:0] ROW_COLOUR = {6'b000011, 6'b001100, 6'b111000, 6'b110000};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_RESP   = 2'd2
    } hit_state_e;

    typedef struct packed {
        logic       in_field;
        logic       gap;
        logic [1:0] row;
        logic [2:0] col;
    } cell_t;

    // Maps a pixel to its cell; arithmetic is 11 bits wide so columns left of x0 wrap out of range.
    function automatic cell_t locate(input logic [9:0] x, input logic [9:0] y,
                                     input logic [10:0] x0, input logic [10:0] y0);
        cell_t       c;
        logic [10:0] dx;
        logic [10:0] dy;
        dx = {1'b0, x} - x0;
        dy = {1'b0, y} - y0;
        c.in_field = ({1'b0, x} >= x0) && (dx < 11'(NUM_COLS * CELL_W)) &&
                     ({1'b0, y} >= y0) && (dy < 11'(NUM_ROWS * CELL_H));
        c.gap = (dx[5:0] == 6'd0) || (dy[3:0] == 4'd0);
        c.col = dx[8:6];
        c.row = dy[5:4];
        return c;
    endfunction

endpackage

// File: rtl/p18_blocks_layer_if.sv
// rtl/p18_blocks_layer_if.sv - ball collision query handshake between ball logic and blocks layer
interface p18_blocks_layer_if;
    logic       hit_req;
    logic [9:0] hit_x;
    logic [9:0] hit_y;
    logic       hit_ack;
    logic       hit_hit;

    modport master (output hit_req, output hit_x, output hit_y, input hit_ack, input hit_hit);
    modport slave  (input hit_req, input hit_x, input hit_y, output hit_ack, output hit_hit);
endinterface

// File: rtl/p18_block_grid.sv
// rtl/p18_block_grid.sv - 32 alive bits plus live-block counter with load and single-cell clear
module p18_block_grid
    import p18_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        clr_i,
    input  logic [4:0]  clr_idx_i,
    output logic [31:0] alive_o,
    output logic [5:0]  remaining_o
);

    logic [31:0] alive_q;
    logic [5:0]  remaining_q;

    // Load has priority over a clear landing on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q     <= '1;
            remaining_q <= 6'(NUM_CELLS);
        end else if (load_i) begin
            alive_q     <= '1;
            remaining_q <= 6'(NUM_CELLS);
        end else if (clr_i && alive_q[clr_idx_i] && (remaining_q != 6'd0)) begin
            alive_q[clr_idx_i] <= 1'b0;
            remaining_q        <= remaining_q - 6'd1;
        end
    end

    assign alive_o     = alive_q;
    assign remaining_o = remaining_q;

endmodule

// File: rtl/p18_blocks_layer.sv
// rtl/p18_blocks_layer.sv - breakout block field: pixel renderer and ball collision query FSM
module p18_blocks_layer
    import p18_pkg::*;
#(
    parameter int GRID_X0 = 64,
    parameter int GRID_Y0 = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           pix_x,
    input  logic [9:0]           pix_y,
    output logic [5:0]           blocks,
    output logic                 blocks_en,
    p18_blocks_layer_if.slave    hit,
    input  logic                 level_load,
    output logic [5:0]           remaining,
    output logic                 all_cleared
);

    localparam logic [10:0] X0 = 11'(GRID_X0);
    localparam logic [10:0] Y0 = 11'(GRID_Y0);

    logic [31:0] alive;
    logic        clr_ok;
    logic        clr_en;
    cell_t       pix_cell;
    cell_t       hit_cell;

    hit_state_e  state_q;
    logic [9:0]  hx_q, hy_q;
    logic        ack_q, hit_q;
    logic [5:0]  blocks_q, blocks_d;
    logic        blocks_en_q, blocks_en_d;

    p18_block_grid u_grid (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (level_load),
        .clr_i       (clr_en),
        .clr_idx_i   ({hit_cell.row, hit_cell.col}),
        .alive_o     (alive),
        .remaining_o (remaining)
    );

    always_comb begin
        pix_cell    = locate(pix_x, pix_y, X0, Y0);
        blocks_en_d = pix_cell.in_field && !pix_cell.gap && alive[{pix_cell.row, pix_cell.col}];
        blocks_d    = blocks_en_d ? ROW_COLOUR[pix_cell.row] : 6'b000000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blocks_q    <= 6'b000000;
            blocks_en_q <= 1'b0;
        end else begin
            blocks_q    <= blocks_d;
            blocks_en_q <= blocks_en_d;
        end
    end

    always_comb begin
        hit_cell = locate(hx_q, hy_q, X0, Y0);
        clr_ok   = hit_cell.in_field && !hit_cell.gap && alive[{hit_cell.row, hit_cell.col}];
        clr_en   = (state_q == S_LOOKUP) && clr_ok;
    end

    // A level load in LOOKUP restores the grid, so the pending response must not claim a hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hx_q    <= 10'd0;
            hy_q    <= 10'd0;
            ack_q   <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            hit_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (hit.hit_req) begin
                        hx_q    <= hit.hit_x;
                        hy_q    <= hit.hit_y;
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    ack_q   <= 1'b1;
                    hit_q   <= clr_ok && !level_load;
                    state_q <= S_RESP;
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign hit.hit_ack  = ack_q;
    assign hit.hit_hit  = hit_q;
    assign blocks       = blocks_q;
    assign blocks_en    = blocks_en_q;
    assign all_cleared  = (remaining == 6'd0);

endmodule
